// File: rtl/icache_sa.sv
// Set-associative instruction cache: round-robin replacement, one-cycle flush, optional early restart (ICACHE_FWD_EN).
// Latency: hits combinational; miss raises mc_ena one cycle later and refills BLOCK_WORDS words in order.
// Backpressure: mc_valid paces the refill; rdy low freezes all state and drops any word offered that cycle.
module icache_sa #(
    parameter int WAYS        = 2,
    parameter int SETS        = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              fet_req,
    input  logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic              mc_ena,
    output logic [ADDR_W-1:0] mc_addr,
    input  logic              mc_valid,
    input  logic [31:0]       mc_data
);
    localparam int WSEL_W = $clog2(BLOCK_WORDS);
    localparam int OFF    = WSEL_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_nxt;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [31:0]       data_q  [SETS][WAYS][BLOCK_WORDS];

    logic [WSEL_W-1:0] fill_k;
    logic [WAY_W-1:0]  victim;
    logic              victim_rr;

    logic [WSEL_W-1:0] pc_wsel;
    logic [IDX_W-1:0]  pc_idx, fill_idx;
    logic [TAG_W-1:0]  pc_tag, fill_tag;
    logic              hit, inv_found, last_word, accept;
    logic [WAY_W-1:0]  hit_way, inv_way, victim_sel, rr_next;
    logic              unused_pc_lsb;

    assign pc_wsel  = pc[OFF-1:2];
    assign pc_idx   = pc[OFF+IDX_W-1:OFF];
    assign pc_tag   = pc[ADDR_W-1:OFF+IDX_W];
    // The line being filled is identified by mc_addr, whose upper bits never change during a fill.
    assign fill_idx = mc_addr[OFF+IDX_W-1:OFF];
    assign fill_tag = mc_addr[ADDR_W-1:OFF+IDX_W];
    assign unused_pc_lsb = ^pc[1:0];

    assign mc_ena     = (state == FILL);
    assign last_word  = (fill_k == WSEL_W'(BLOCK_WORDS - 1));
    assign accept     = rdy && !flush && (state == FILL) && mc_valid;
    assign victim_sel = inv_found ? inv_way : rr_q[pc_idx];
    assign rr_next    = (rr_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[fill_idx] + WAY_W'(1);

    // Scanning downwards leaves the lowest-numbered match / invalid way selected.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[pc_idx][w] && (tag_q[pc_idx][w] == pc_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[pc_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    always_comb begin
        instr_valid = fet_req && hit;
        instr       = data_q[pc_idx][hit_way][pc_wsel];
`ifdef ICACHE_FWD_EN
        if (fet_req && accept && (pc == mc_addr)) begin
            instr_valid = 1'b1;
            instr       = mc_data;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fet_req && !hit && !flush) state_nxt = FILL;
            FILL: if (flush || (mc_valid && last_word)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mc_addr   <= '0;
            fill_k    <= '0;
            victim    <= '0;
            victim_rr <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (rdy) begin
            state <= state_nxt;
            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end else if (state == IDLE) begin
                if (fet_req && !hit) begin
                    mc_addr   <= {pc[ADDR_W-1:OFF], {OFF{1'b0}}};
                    fill_k    <= '0;
                    victim    <= victim_sel;
                    victim_rr <= !inv_found;
                    valid_q[pc_idx][victim_sel] <= 1'b0;
                end
            end else if (mc_valid) begin
                mc_addr <= mc_addr + ADDR_W'(4);
                fill_k  <= fill_k + WSEL_W'(1);
                if (last_word) begin
                    valid_q[fill_idx][victim] <= 1'b1;
                    if (victim_rr) rr_q[fill_idx] <= rr_next;
                end
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits alone decide what can hit.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q[fill_idx][victim][fill_k] <= mc_data;
            if (last_word) tag_q[fill_idx][victim] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
module tb_icache_sa;
    logic        clk = 1'b0;
    logic        rst, rdy, flush, fet_req, mc_valid;
    logic [31:0] pc, mc_data;
    logic        instr_valid, mc_ena;
    logic [31:0] instr, mc_addr;

`ifdef ICACHE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int n_pass = 0;
    int n_total = 0;

    // Reference: per set, which line tag sits in which way plus its words.
    bit          mdl_valid [16][2];
    logic [23:0] mdl_tag   [16][2];
    logic [31:0] mdl_data  [16][2][4];
    int          mdl_rr    [16];

    icache_sa dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .fet_req(fet_req), .pc(pc),
        .instr_valid(instr_valid), .instr(instr), .mc_ena(mc_ena), .mc_addr(mc_addr),
        .mc_valid(mc_valid), .mc_data(mc_data)
    );

    always #5 clk = ~clk;

    function automatic void mdl_clear();
        for (int s = 0; s < 16; s++) begin
            mdl_rr[s] = 0;
            for (int w = 0; w < 2; w++) mdl_valid[s][w] = 1'b0;
        end
    endfunction

    function automatic void mdl_lookup(input logic [31:0] a, output bit h, output logic [31:0] d);
        int s = int'(a[7:4]);
        h = 1'b0;
        d = '0;
        for (int w = 0; w < 2; w++)
            if (mdl_valid[s][w] && mdl_tag[s][w] == a[31:8]) begin
                h = 1'b1;
                d = mdl_data[s][w][a[3:2]];
            end
    endfunction

    function automatic logic [31:0] pool_addr();
        logic [31:0] t = $urandom_range(0, 3);
        logic [31:0] s = $urandom_range(0, 2);
        logic [31:0] k = $urandom_range(0, 3);
        return (t << 8) | (s << 4) | (k << 2);
    endfunction

    // Drives one fetch; on a predicted miss it plays the memory controller for the refill.
    // abort_after>0: flush after that many words. stall_at>=0: rdy low 5 cycles before that word.
    task automatic do_access(input logic [31:0] a, input logic [31:0] dbase, input int abort_after,
                             input int stall_at, input int max_gap, input bit peek);
        bit          eh, from_rr;
        logic [31:0] ed, base, pa;
        logic [31:0] w [4];
        int          s, way, ws;
        s    = int'(a[7:4]);
        ws   = int'(a[3:2]);
        base = {a[31:4], 4'h0};
        @(negedge clk);
        pc = a; fet_req = 1'b1; mc_valid = 1'b0; rdy = 1'b1;
        #2;
        mdl_lookup(a, eh, ed);
        n_total++;
        if (instr_valid !== eh || (eh && instr !== ed))
            $display("FAIL lookup %h: valid=%b instr=%h, want valid=%b instr=%h", a, instr_valid, instr, eh, ed);
        else n_pass++;
        if (eh) return;
        way = -1;
        for (int i = 0; i < 2; i++) if (!mdl_valid[s][i] && way < 0) way = i;
        from_rr = (way < 0);
        if (from_rr) way = mdl_rr[s];
        mdl_valid[s][way] = 1'b0;
        for (int k = 0; k < 4; k++) w[k] = (dbase != 0) ? dbase + k : $urandom;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(negedge clk);
                mc_valid = 1'b0;
                pa = peek ? pool_addr() : a;
                pc = pa;
                #2;
                mdl_lookup(pa, eh, ed);
                n_total++;
                if (mc_ena !== 1'b1 || instr_valid !== eh || (eh && instr !== ed))
                    $display("FAIL gap %h: mc_ena=%b valid=%b instr=%h, want 1 %b %h", pa, mc_ena, instr_valid, instr, eh, ed);
                else n_pass++;
            end
            if (k == stall_at) begin
                repeat (5) begin
                    @(negedge clk);
                    pc = a; rdy = 1'b0; mc_valid = 1'b1; mc_data = ~w[k];
                    #2;
                    n_total++;
                    if (mc_addr !== base + 4 * k || mc_ena !== 1'b1 || instr_valid !== 1'b0)
                        $display("FAIL stall: mc_addr=%h mc_ena=%b valid=%b, want %h 1 0", mc_addr, mc_ena, instr_valid, base + 4 * k);
                    else n_pass++;
                end
            end
            @(negedge clk);
            pc = a; rdy = 1'b1; mc_valid = 1'b1; mc_data = w[k];
            #2;
            n_total++;
            if (mc_ena !== 1'b1 || mc_addr !== base + 4 * k)
                $display("FAIL refill req %0d: mc_ena=%b mc_addr=%h, want 1 %h", k, mc_ena, mc_addr, base + 4 * k);
            else n_pass++;
            n_total++;
            if (instr_valid !== (FWD && k == ws) || (FWD && k == ws && instr !== w[k]))
                $display("FAIL fill word %0d: valid=%b instr=%h, want valid=%b", k, instr_valid, instr, FWD && k == ws);
            else n_pass++;
            if (abort_after == k + 1) begin
                @(negedge clk);
                mc_valid = 1'b0; flush = 1'b1; fet_req = 1'b0;
                @(negedge clk);
                flush = 1'b0; mc_valid = 1'b1; mc_data = 32'hDEAD_BEEF;
                #2;
                n_total++;
                if (mc_ena !== 1'b0) $display("FAIL flush abort: mc_ena=%b, want 0", mc_ena);
                else n_pass++;
                @(negedge clk);
                mc_valid = 1'b0;
                #2;
                n_total++;
                if (mc_ena !== 1'b0) $display("FAIL late word: mc_ena=%b, want 0", mc_ena);
                else n_pass++;
                mdl_clear();
                return;
            end
        end
        @(negedge clk);
        mc_valid = 1'b0;
        mdl_valid[s][way] = 1'b1;
        mdl_tag[s][way] = a[31:8];
        for (int k = 0; k < 4; k++) mdl_data[s][way][k] = w[k];
        if (from_rr) mdl_rr[s] = (mdl_rr[s] + 1) % 2;
        #2;
        n_total++;
        if (mc_ena !== 1'b0 || instr_valid !== 1'b1 || instr !== w[ws])
            $display("FAIL post-fill %h: mc_ena=%b valid=%b instr=%h, want 0 1 %h", a, mc_ena, instr_valid, instr, w[ws]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; mc_valid = 1'b0; mc_data = '0;
        fet_req = 1'b1; pc = 32'h100;
        #3;
        n_total++;
        if (mc_ena !== 1'b0 || mc_addr !== 32'h0 || instr_valid !== 1'b0)
            $display("FAIL reset: mc_ena=%b mc_addr=%h valid=%b, want 0 0 0", mc_ena, mc_addr, instr_valid);
        else n_pass++;
        fet_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mdl_clear();
    endtask

    task automatic test_cold_miss();
        do_access(32'h100, 32'hA0, 0, -1, 0, 1'b0);
        @(negedge clk);
        pc = 32'h108; fet_req = 1'b1;
        #2;
        n_total++;
        if (instr_valid !== 1'b1 || instr !== 32'hA2)
            $display("FAIL cold hit 0x108: valid=%b instr=%h, want 1 000000a2", instr_valid, instr);
        else n_pass++;
    endtask

    task automatic test_assoc();
        do_access(32'h200, 0, 0, -1, 1, 1'b0);
        do_access(32'h104, 0, 0, -1, 0, 1'b0);
        do_access(32'h20C, 0, 0, -1, 0, 1'b0);
        do_access(32'h300, 0, 0, -1, 1, 1'b0);
        @(negedge clk);
        rdy = 1'b0; fet_req = 1'b1; pc = 32'h100;
        #1;
        n_total++;
        if (instr_valid !== 1'b0) $display("FAIL evict 0x100: valid=%b, want 0", instr_valid);
        else n_pass++;
        pc = 32'h200;
        #1;
        n_total++;
        if (instr_valid !== 1'b1) $display("FAIL keep 0x200: valid=%b, want 1", instr_valid);
        else n_pass++;
        rdy = 1'b1; fet_req = 1'b0;
        do_access(32'h100, 0, 0, -1, 0, 1'b0);
        @(negedge clk);
        rdy = 1'b0; fet_req = 1'b1; pc = 32'h200;
        #1;
        n_total++;
        if (instr_valid !== 1'b0) $display("FAIL rr evict 0x200: valid=%b, want 0", instr_valid);
        else n_pass++;
        rdy = 1'b1; fet_req = 1'b0;
    endtask

    task automatic test_flush_mid_fill();
        do_access(32'h400, 0, 2, -1, 0, 1'b0);
        @(negedge clk);
        rdy = 1'b0; fet_req = 1'b1; pc = 32'h400;
        #1;
        n_total++;
        if (instr_valid !== 1'b0) $display("FAIL flushed 0x400: valid=%b, want 0", instr_valid);
        else n_pass++;
        pc = 32'h100;
        #1;
        n_total++;
        if (instr_valid !== 1'b0) $display("FAIL flushed 0x100: valid=%b, want 0", instr_valid);
        else n_pass++;
        rdy = 1'b1; fet_req = 1'b0;
        do_access(32'h100, 0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_rdy_stall();
        do_access(32'h400, 0, 0, 2, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        pc = 32'h500; fet_req = 1'b1; mc_valid = 1'b0;
        @(negedge clk);
        mc_valid = 1'b1; mc_data = $urandom;
        #2;
        n_total++;
        if (mc_ena !== 1'b1 || mc_addr !== 32'h500)
            $display("FAIL pre-reset fill: mc_ena=%b mc_addr=%h, want 1 00000500", mc_ena, mc_addr);
        else n_pass++;
        @(negedge clk);
        mc_valid = 1'b0; pc = 32'h400;
        #1;
        n_total++;
        if (instr_valid !== 1'b1) $display("FAIL hit other line in fill: valid=%b, want 1", instr_valid);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (mc_ena !== 1'b0 || instr_valid !== 1'b0 || mc_addr !== 32'h0)
            $display("FAIL async reset: mc_ena=%b valid=%b mc_addr=%h, want 0 0 0", mc_ena, instr_valid, mc_addr);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (instr_valid !== 1'b0) $display("FAIL after reset: valid=%b, want 0", instr_valid);
        else n_pass++;
        fet_req = 1'b0;
        mdl_clear();
        @(negedge clk);
        rdy = 1'b0; fet_req = 1'b1; pc = 32'h100;
        #1;
        n_total++;
        if (instr_valid !== 1'b0) $display("FAIL after reset 0x100: valid=%b, want 0", instr_valid);
        else n_pass++;
        rdy = 1'b1; fet_req = 1'b0;
        do_access(32'h400, 0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_forward();
        do_access(32'h504, 0, 0, -1, 0, 1'b0);
        do_access(32'h60C, 0, 0, -1, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                fet_req = 1'b0; pc = pool_addr();
                #2;
                n_total++;
                if (instr_valid !== 1'b0) $display("FAIL idle %h: valid=%b, want 0", pc, instr_valid);
                else n_pass++;
            end
            do_access(pool_addr(), 0, 0, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, 2, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_assoc();
        test_flush_mid_fill();
        test_rdy_stall();
        test_async_reset();
        test_forward();
        test_random();
        @(negedge clk);
        fet_req = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
